// File: rtl/mc_main_ctrl_if.sv
// Control bundle between the multicycle RV32I controller and its datapath:
// latched instruction fields and zero flag in, every select/enable out.
interface mc_main_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;

    // Controller side
    modport master (
        input  op, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control
    );

    // Datapath side
    modport slave (
        output op, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control
    );
endinterface

// File: rtl/mc_main_ctrl.sv
// Multicycle RV32I control unit: Moore main FSM, immediate-source decoder,
// ALU decoder, plus retired-instruction and cycle counters for debug.
module mc_main_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    mc_main_ctrl_if.master   bus,
    output logic [3:0]       state,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] cycles
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    state_t     state_q, state_d;
    logic       pc_update, branch;
    logic       ir_write_s, mem_write_s, reg_write_s;
    logic [1:0] alu_op;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; combinational blocks below use blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            instret <= '0;
            cycles  <= '0;
        end else begin
            state_q <= state_d;
            cycles  <= cycles + CNT_W'(1);
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

    assign state = state_q;

    // NOTE: every output gets a default before the case so no path through
    // the block leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d       = S_FETCH;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_s    = 1'b0;
        mem_write_s   = 1'b0;
        reg_write_s   = 1'b0;
        alu_op        = 2'b00;
        retire        = 1'b0;
        illegal       = 1'b0;
        bus.adr_src    = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;

        case (state_q)
            S_FETCH: begin
                state_d        = S_DECODE;
                ir_write_s     = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                pc_update      = 1'b1;
            end
            S_DECODE: begin
                // Branch/jump target is precomputed here from old_pc + imm
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BEQ:            state_d = S_BEQ;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                        retire  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                state_d       = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                state_d     = S_MEMWB;
                bus.adr_src = 1'b1;
            end
            S_MEMWB: begin
                bus.result_src = 2'b01;
                reg_write_s    = 1'b1;
                retire         = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src = 1'b1;
                mem_write_s = 1'b1;
                retire      = 1'b1;
            end
            S_EXECR: begin
                state_d       = S_ALUWB;
                bus.alu_src_a = 2'b10;
                alu_op        = 2'b10;
            end
            S_EXECI: begin
                state_d       = S_ALUWB;
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                alu_op        = 2'b10;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                retire      = 1'b1;
            end
            S_JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                pc_update     = 1'b1;
                retire        = 1'b1;
            end
            S_BEQ: begin
                bus.alu_src_a = 2'b10;
                alu_op        = 2'b01;
                branch        = 1'b1;
                retire        = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write enables are held off while reset is asserted
    assign bus.pc_write  = ~rst & (pc_update | (branch & bus.zero));
    assign bus.ir_write  = ~rst & ir_write_s;
    assign bus.mem_write = ~rst & mem_write_s;
    assign bus.reg_write = ~rst & reg_write_s;

    always_comb begin
        case (bus.op)
            OP_STORE: bus.imm_src = 2'b01;
            OP_BEQ:   bus.imm_src = 2'b10;
            OP_JAL:   bus.imm_src = 2'b11;
            default:  bus.imm_src = 2'b00;
        endcase
    end

    always_comb begin
        bus.alu_control = 3'b000;
        case (alu_op)
            2'b01: bus.alu_control = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    // Only R-type may subtract; addi with bit30 set stays add
                    3'b000:  bus.alu_control = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  bus.alu_control = 3'b101;
                    3'b110:  bus.alu_control = 3'b011;
                    3'b111:  bus.alu_control = 3'b010;
                    default: bus.alu_control = 3'b000;
                endcase
            end
            default: bus.alu_control = 3'b000;
        endcase
    end
endmodule

// File: tb/tb_mc_main_ctrl.sv
// Bench for mc_main_ctrl (CNT_W=4 so counter wrap is reachable): vector table,
// hand sequences for reset/wrap, and random instructions against a per-instruction model.
module tb_mc_main_ctrl;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       state;
    logic             retire, illegal;
    logic [CNT_W-1:0] instret, cycles;

    mc_main_ctrl_if bus ();

    mc_main_ctrl #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.master),
        .state   (state),
        .retire  (retire),
        .illegal (illegal),
        .instret (instret),
        .cycles  (cycles)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [CNT_W-1:0] m_instret = '0;
    logic [CNT_W-1:0] m_cycles  = '0;

    typedef enum int {K_LW, K_SW, K_R, K_I, K_JAL, K_BEQ, K_BAD} kind_t;

    typedef struct packed {
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu;
        logic       ret, ill;
    } ctrl_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         len;
        logic [2:0] alu;
        logic [1:0] imm;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic kind_t kind_of(logic [6:0] o);
        case (o)
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b1101111: return K_JAL;
            7'b1100011: return K_BEQ;
            default:    return K_BAD;
        endcase
    endfunction

    function automatic logic [6:0] op_of(kind_t k);
        case (k)
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_JAL:   return 7'b1101111;
            K_BEQ:   return 7'b1100011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int model_len(kind_t k);
        case (k)
            K_LW:             return 5;
            K_SW, K_R, K_I:   return 4;
            K_JAL, K_BEQ:     return 3;
            default:          return 2;
        endcase
    endfunction

    function automatic int exp_state(kind_t k, int i);
        if (i < 2) return i;
        case (k)
            K_LW:    return i;
            K_SW:    return (i == 2) ? 2 : 5;
            K_R:     return (i == 2) ? 6 : 7;
            K_I:     return (i == 2) ? 8 : 7;
            K_JAL:   return 9;
            K_BEQ:   return 10;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(kind_t k);
        case (k)
            K_SW:    return 2'b01;
            K_BEQ:   return 2'b10;
            K_JAL:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // add/sub/slt/or/and by mnemonic; sub_ok is true only for R-type with bit30
    function automatic logic [2:0] alu_for(logic [2:0] f3, logic sub_ok);
        case (f3)
            3'b000:  return sub_ok ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected controls at step i of an instruction (step 0 is FETCH)
    function automatic ctrl_t exp_ctrl(kind_t k, logic [2:0] f3, logic f7, logic z, int i);
        ctrl_t c = '0;
        case (i)
            0: begin c.pcw = 1; c.irw = 1; c.sb = 2'b10; c.rs = 2'b10; end
            1: begin
                c.sa = 2'b01; c.sb = 2'b01;
                if (k == K_BAD) begin c.ret = 1; c.ill = 1; end
            end
            2: case (k)
                K_LW, K_SW: begin c.sa = 2'b10; c.sb = 2'b01; end
                K_R:   begin c.sa = 2'b10; c.alu = alu_for(f3, f7); end
                K_I:   begin c.sa = 2'b10; c.sb = 2'b01; c.alu = alu_for(f3, 1'b0); end
                K_JAL: begin c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1; c.ret = 1; end
                K_BEQ: begin c.sa = 2'b10; c.alu = 3'b001; c.pcw = z; c.ret = 1; end
                default: ;
            endcase
            3: case (k)
                K_LW:     c.adr = 1;
                K_SW:     begin c.adr = 1; c.mw = 1; c.ret = 1; end
                K_R, K_I: begin c.rw = 1; c.ret = 1; end
                default: ;
            endcase
            4: if (k == K_LW) begin c.rs = 2'b01; c.rw = 1; c.ret = 1; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic tick(input logic ret_exp);
        @(posedge clk);
        if (rst) begin
            m_cycles  = '0;
            m_instret = '0;
        end else begin
            m_cycles = m_cycles + 1'b1;
            if (ret_exp) m_instret = m_instret + 1'b1;
        end
        #1;
    endtask

    // Runs one instruction from FETCH until state returns to FETCH (bounded)
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, output int lat, output logic [2:0] alu2);
        kind_t k = kind_of(o);
        int    n = model_len(k);
        ctrl_t e;
        logic  r;
        bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
        lat = 0; alu2 = 3'b000;
        do begin
            #1;
            r = 1'b0;
            if (lat < n) begin
                e = exp_ctrl(k, f3, f7, z, lat);
                r = e.ret;
                check("state",       32'(state),           32'(exp_state(k, lat)));
                check("pc_write",    32'(bus.pc_write),    32'(e.pcw));
                check("adr_src",     32'(bus.adr_src),     32'(e.adr));
                check("mem_write",   32'(bus.mem_write),   32'(e.mw));
                check("ir_write",    32'(bus.ir_write),    32'(e.irw));
                check("reg_write",   32'(bus.reg_write),   32'(e.rw));
                check("result_src",  32'(bus.result_src),  32'(e.rs));
                check("alu_src_a",   32'(bus.alu_src_a),   32'(e.sa));
                check("alu_src_b",   32'(bus.alu_src_b),   32'(e.sb));
                check("alu_control", 32'(bus.alu_control), 32'(e.alu));
                check("retire",      32'(retire),          32'(e.ret));
                check("illegal",     32'(illegal),         32'(e.ill));
                check("imm_src",     32'(bus.imm_src),     32'(exp_imm(k)));
                check("instret",     32'(instret),         32'(m_instret));
                check("cycles",      32'(cycles),          32'(m_cycles));
            end
            if (lat == 2) alu2 = bus.alu_control;
            tick(r);
            lat++;
        end while (state != 4'd0 && lat < 10);
        if (lat >= 10) check("fetch_timeout", 32'(state), 32'd0);
    endtask

    vec_t  vecs[$];
    int    lat;
    logic  [2:0] alu2;
    kind_t rk;
    logic  [6:0] rop;

    initial begin
        bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.zero = 1'b0;

        // Reset from power-up
        rst = 1'b1;
        repeat (3) tick(1'b0);
        rst = 1'b0;
        #1;
        check("rst_state",   32'(state),   32'd0);
        check("rst_instret", 32'(instret), 32'd0);
        check("rst_cycles",  32'(cycles),  32'd0);

        //            op           f3      f7    z     len alu     imm
        vecs.push_back('{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 3'b000, 2'b00}); // lw
        vecs.push_back('{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 3'b000, 2'b01}); // sw
        vecs.push_back('{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 3'b001, 2'b00}); // sub
        vecs.push_back('{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 3'b000, 2'b00}); // add
        vecs.push_back('{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 3'b101, 2'b00}); // slt
        vecs.push_back('{7'b0110011, 3'b110, 1'b0, 1'b0, 4, 3'b011, 2'b00}); // or
        vecs.push_back('{7'b0110011, 3'b111, 1'b0, 1'b0, 4, 3'b010, 2'b00}); // and
        vecs.push_back('{7'b0110011, 3'b100, 1'b1, 1'b0, 4, 3'b000, 2'b00}); // other funct3
        vecs.push_back('{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 3'b000, 2'b00}); // addi bit30
        vecs.push_back('{7'b0010011, 3'b010, 1'b0, 1'b0, 4, 3'b101, 2'b00}); // slti
        vecs.push_back('{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 3'b001, 2'b10}); // beq taken
        vecs.push_back('{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 3'b001, 2'b10}); // beq not taken
        vecs.push_back('{7'b1101111, 3'b000, 1'b0, 1'b0, 3, 3'b000, 2'b11}); // jal
        vecs.push_back('{7'b0000000, 3'b000, 1'b0, 1'b0, 2, 3'b000, 2'b00}); // illegal

        for (int i = 0; i < vecs.size(); i++) begin
            run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, lat, alu2);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].len));
            check($sformatf("vec%0d_alu", i),     32'(alu2), 32'(vecs[i].alu));
            check($sformatf("vec%0d_imm", i),     32'(bus.imm_src), 32'(vecs[i].imm));
        end

        // Reset mid-lw, while sitting in MEMWB with reg_write active
        bus.op = 7'b0000011;
        for (int i = 0; i < 4; i++) tick(1'b0);
        check("midlw_state", 32'(state), 32'd4);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst_reg_write", 32'(bus.reg_write), 32'd0);
            check("rst_mem_write", 32'(bus.mem_write), 32'd0);
            check("rst_ir_write",  32'(bus.ir_write),  32'd0);
            check("rst_pc_write",  32'(bus.pc_write),  32'd0);
            tick(1'b0);
            check("rst_hold_state", 32'(state), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("midlw_rst_state",   32'(state),   32'd0);
        check("midlw_rst_instret", 32'(instret), 32'd0);
        check("midlw_rst_cycles",  32'(cycles),  32'd0);

        // instret wrap at 2^CNT_W using illegal ops
        for (int i = 0; i < 15; i++) run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, lat, alu2);
        check("instret_max", 32'(instret), 32'd15);
        run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, lat, alu2);
        check("instret_wrap", 32'(instret), 32'd0);

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            rk = kind_t'($urandom_range(0, 6));
            if (rk == K_BAD) begin
                do rop = 7'($urandom); while (kind_of(rop) != K_BAD);
            end else begin
                rop = op_of(rk);
            end
            run_instr(rop, 3'($urandom), 1'($urandom), 1'($urandom), lat, alu2);
            check("rand_latency", 32'(lat), 32'(model_len(kind_of(rop))));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
